// File: rtl/ecc_scalar_mult_seq_if.sv
// rtl/ecc_scalar_mult_seq_if.sv - operand, handshake and result bus of the scalar multiplier
interface ecc_scalar_mult_seq_if #(
  parameter int M   = 4,
  parameter int K_W = 4
);
  logic           start;
  logic [K_W-1:0] k;
  logic [M-1:0]   px;
  logic [M-1:0]   py;
  logic           p_inf;
  logic [M-1:0]   a;
  logic [M:0]     f;
  logic           busy;
  logic           done;
  logic [M-1:0]   qx;
  logic [M-1:0]   qy;
  logic           q_inf;

  modport master (
    output start, k, px, py, p_inf, a, f,
    input  busy, done, qx, qy, q_inf
  );

  modport slave (
    input  start, k, px, py, p_inf, a, f,
    output busy, done, qx, qy, q_inf
  );
endinterface

// File: rtl/ecc_scalar_mult_seq.sv
// rtl/ecc_scalar_mult_seq.sv - sequential Q = k*P over GF(2^M), left-to-right double-and-add
// One shared point datapath; inversion by Fermat squaring chain, one step per clock.
module ecc_scalar_mult_seq #(
  parameter int M   = 4,
  parameter int K_W = 4
) (
  input logic                clock,
  input logic                reset,
  ecc_scalar_mult_seq_if.slave bus
);
  localparam int IDX_W = (K_W > 1) ? $clog2(K_W) : 1;
  localparam int CNT_W = (M > 2) ? $clog2(M - 1) : 1;
  localparam logic [M-1:0] ONE = M'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SCAN, S_DBL, S_INV, S_DBL_FIN,
    S_CHK, S_ADD, S_ADD_FIN, S_NEXT, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic [M-1:0]   px_q, px_d, py_q, py_d, a_q, a_d;
  logic [M:0]     f_q, f_d;
  logic           pinf_q, pinf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [M-1:0]   rx_q, rx_d, ry_q, ry_d;
  logic           rinf_q, rinf_d;
  logic [M-1:0]   inv_t_q, inv_t_d, inv_r_q, inv_r_d;
  logic [CNT_W-1:0] inv_cnt_q, inv_cnt_d;
  logic           inv_add_q, inv_add_d;
  logic           add_dbl_q, add_dbl_d;
  logic [M-1:0]   qx_q, qx_d, qy_q, qy_d;
  logic           qinf_q, qinf_d;

  // MSB-first shift-and-add multiply, reducing by f after every shift
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y,
                                          input logic [M:0] fp);
    logic [M-1:0] acc;
    acc = '0;
    for (int i = M - 1; i >= 0; i--) begin
      acc = {acc[M-2:0], 1'b0} ^ ({M{acc[M-1] & fp[M]}} & fp[M-1:0]);
      if (y[i]) acc = acc ^ x;
    end
    return acc;
  endfunction

  logic [M-1:0] t_sq, r_next, rx_sq;
  logic [M-1:0] dbl_lam, dbl_x3, dbl_y3;
  logic [M-1:0] add_lam, add_x3, add_y3;
  logic         dbl_trivial, add_needs_inv, last_inv;

  assign t_sq    = gf_mul(inv_t_q, inv_t_q, f_q);
  assign r_next  = gf_mul(inv_r_q, t_sq, f_q);
  assign rx_sq   = gf_mul(rx_q, rx_q, f_q);
  // inv_r_q holds the inverse of whichever operand the last INV run was seeded with
  assign dbl_lam = rx_q ^ gf_mul(ry_q, inv_r_q, f_q);
  assign dbl_x3  = gf_mul(dbl_lam, dbl_lam, f_q) ^ dbl_lam ^ a_q;
  assign dbl_y3  = rx_sq ^ gf_mul(dbl_lam ^ ONE, dbl_x3, f_q);
  assign add_lam = gf_mul(ry_q ^ py_q, inv_r_q, f_q);
  assign add_x3  = gf_mul(add_lam, add_lam, f_q) ^ add_lam ^ rx_q ^ px_q ^ a_q;
  assign add_y3  = gf_mul(add_lam, rx_q ^ add_x3, f_q) ^ add_x3 ^ ry_q;

  assign dbl_trivial   = rinf_q || (rx_q == '0);
  assign add_needs_inv = !rinf_q && !pinf_q &&
                         ((rx_q != px_q) || ((ry_q == py_q) && (rx_q != '0)));
  assign last_inv      = (inv_cnt_q == CNT_W'(M - 2));

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (bus.start) state_d = S_LOAD;
      S_LOAD:    state_d = S_SCAN;
      S_SCAN:    state_d = S_DBL;
      S_DBL:     state_d = dbl_trivial ? S_CHK : S_INV;
      S_INV:     if (last_inv) state_d = inv_add_q ? S_ADD_FIN : S_DBL_FIN;
      S_DBL_FIN: state_d = S_CHK;
      S_CHK:     state_d = k_q[idx_q] ? S_ADD : S_NEXT;
      S_ADD:     state_d = add_needs_inv ? S_INV : S_NEXT;
      S_ADD_FIN: state_d = S_NEXT;
      S_NEXT:    state_d = (idx_q == '0) ? S_DONE : S_SCAN;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_DONE);
  end

  assign bus.qx    = qx_q;
  assign bus.qy    = qy_q;
  assign bus.q_inf = qinf_q;

  always_comb begin
    k_d = k_q;  px_d = px_q;  py_d = py_q;  pinf_d = pinf_q;  a_d = a_q;  f_d = f_q;
    idx_d = idx_q;  rx_d = rx_q;  ry_d = ry_q;  rinf_d = rinf_q;
    inv_t_d = inv_t_q;  inv_r_d = inv_r_q;  inv_cnt_d = inv_cnt_q;
    inv_add_d = inv_add_q;  add_dbl_d = add_dbl_q;
    qx_d = qx_q;  qy_d = qy_q;  qinf_d = qinf_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          k_d = bus.k;  px_d = bus.px;  py_d = bus.py;
          pinf_d = bus.p_inf;  a_d = bus.a;  f_d = bus.f;
        end
      end
      S_LOAD: begin
        idx_d = IDX_W'(K_W - 1);
        rx_d = '0;  ry_d = '0;  rinf_d = 1'b1;
      end
      S_DBL: begin
        if (dbl_trivial) begin
          rx_d = '0;  ry_d = '0;  rinf_d = 1'b1;
        end else begin
          inv_t_d = rx_q;  inv_r_d = ONE;  inv_cnt_d = '0;  inv_add_d = 1'b0;
        end
      end
      S_INV: begin
        inv_t_d   = t_sq;
        inv_r_d   = r_next;
        inv_cnt_d = inv_cnt_q + CNT_W'(1);
      end
      S_DBL_FIN: begin
        rx_d = dbl_x3;  ry_d = dbl_y3;
      end
      S_ADD: begin
        if (rinf_q) begin
          rx_d = pinf_q ? '0 : px_q;  ry_d = pinf_q ? '0 : py_q;  rinf_d = pinf_q;
        end else if (pinf_q) begin
          rinf_d = rinf_q;
        end else if (add_needs_inv) begin
          // equal x and y with x != 0 means R == P, so fall back to doubling R
          add_dbl_d = (rx_q == px_q);
          inv_t_d   = (rx_q == px_q) ? rx_q : (rx_q ^ px_q);
          inv_r_d   = ONE;  inv_cnt_d = '0;  inv_add_d = 1'b1;
        end else begin
          rx_d = '0;  ry_d = '0;  rinf_d = 1'b1;
        end
      end
      S_ADD_FIN: begin
        rx_d = add_dbl_q ? dbl_x3 : add_x3;
        ry_d = add_dbl_q ? dbl_y3 : add_y3;
      end
      S_NEXT: begin
        if (idx_q == '0) begin
          qx_d   = rinf_q ? '0 : rx_q;
          qy_d   = rinf_q ? '0 : ry_q;
          qinf_d = rinf_q;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: begin
        rinf_d = rinf_q;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      k_q <= '0;  px_q <= '0;  py_q <= '0;  pinf_q <= 1'b0;  a_q <= '0;  f_q <= '0;
      idx_q <= '0;  rx_q <= '0;  ry_q <= '0;  rinf_q <= 1'b0;
      inv_t_q <= '0;  inv_r_q <= '0;  inv_cnt_q <= '0;
      inv_add_q <= 1'b0;  add_dbl_q <= 1'b0;
      qx_q <= '0;  qy_q <= '0;  qinf_q <= 1'b1;
    end else begin
      k_q <= k_d;  px_q <= px_d;  py_q <= py_d;  pinf_q <= pinf_d;  a_q <= a_d;  f_q <= f_d;
      idx_q <= idx_d;  rx_q <= rx_d;  ry_q <= ry_d;  rinf_q <= rinf_d;
      inv_t_q <= inv_t_d;  inv_r_q <= inv_r_d;  inv_cnt_q <= inv_cnt_d;
      inv_add_q <= inv_add_d;  add_dbl_q <= add_dbl_d;
      qx_q <= qx_d;  qy_q <= qy_d;  qinf_q <= qinf_d;
    end
  end
endmodule

// File: tb/tb_ecc_scalar_mult_seq.sv
// tb/tb_ecc_scalar_mult_seq.sv - self-checking bench for ecc_scalar_mult_seq (M=4, K_W=4)
module tb_ecc_scalar_mult_seq;
  localparam logic [4:0] F_POLY = 5'b10011;
  localparam logic [3:0] A_COEF = 4'd0;
  localparam int BOUND = 2 + 4 * (2 * (4 - 1) + 6);
  localparam int LIMIT = 200;

  typedef struct packed {
    logic       inf;
    logic [3:0] x;
    logic [3:0] y;
  } pt_t;

  typedef struct packed {
    logic [3:0] k;
    logic [3:0] px;
    logic [3:0] py;
    logic       pinf;
    logic [3:0] ex;
    logic [3:0] ey;
    logic       einf;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  pt_t  sb[$];
  vec_t vecs[8];

  ecc_scalar_mult_seq_if #(.M(4), .K_W(4)) bus ();

  ecc_scalar_mult_seq #(.M(4), .K_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // GF(16) reference: full carry-less product, then fold the top bits back down
  function automatic logic [3:0] m_mul(input logic [3:0] x, input logic [3:0] y);
    logic [6:0] p;
    logic [6:0] fx;
    p  = '0;
    fx = 7'(F_POLY);
    for (int i = 0; i < 4; i++) if (y[i]) p = p ^ (7'(x) << i);
    for (int i = 6; i >= 4; i--) if (p[i]) p = p ^ (fx << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] m_inv(input logic [3:0] x);
    logic [3:0] c;
    for (int i = 1; i < 16; i++) begin
      c = 4'(i);
      if (m_mul(x, c) == 4'd1) return c;
    end
    return 4'd0;
  endfunction

  function automatic pt_t pt_add(input pt_t p1, input pt_t p2);
    pt_t r;
    logic [3:0] lam;
    r = '{inf: 1'b1, x: 4'd0, y: 4'd0};
    if (p1.inf) r = p2;
    else if (p2.inf) r = p1;
    else if (p1.x == p2.x) begin
      if (p1.y == p2.y && p1.x != 4'd0) begin
        lam   = p1.x ^ m_mul(p1.y, m_inv(p1.x));
        r.inf = 1'b0;
        r.x   = m_mul(lam, lam) ^ lam ^ A_COEF;
        r.y   = m_mul(p1.x, p1.x) ^ m_mul(lam, r.x) ^ r.x;
      end
    end else begin
      lam   = m_mul(p1.y ^ p2.y, m_inv(p1.x ^ p2.x));
      r.inf = 1'b0;
      r.x   = m_mul(lam, lam) ^ lam ^ p1.x ^ p2.x ^ A_COEF;
      r.y   = m_mul(lam, p1.x ^ r.x) ^ r.x ^ p1.y;
    end
    return r;
  endfunction

  // k*P by repeated addition rather than double-and-add
  function automatic pt_t m_smul(input int kk, input pt_t p);
    pt_t r;
    r = '{inf: 1'b1, x: 4'd0, y: 4'd0};
    for (int j = 0; j < kk; j++) r = pt_add(r, p);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] kk, input logic [3:0] px_v, input logic [3:0] py_v,
                       input logic pinf_v, input bit push, input pt_t e);
    bus.k = kk;  bus.px = px_v;  bus.py = py_v;  bus.p_inf = pinf_v;
    bus.a = A_COEF;  bus.f = F_POLY;  bus.start = 1'b1;
    if (push) sb.push_back(e);
    @(negedge clock);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    bus.k = 4'($urandom);  bus.px = 4'($urandom);  bus.py = 4'($urandom);
    bus.p_inf = 1'($urandom);  bus.a = 4'($urandom);
  endtask

  task automatic wait_result(input int lat0);
    int  lat;
    bit  busy_ok;
    pt_t e;
    lat     = lat0;
    busy_ok = 1'b1;
    while (!bus.done && lat < LIMIT) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clock);
      lat++;
    end
    if (!bus.done) begin
      checks++;
      failures++;
      $display("FAIL timeout: no done after %0d cycles, required within %0d", lat, BOUND);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: done seen with %0d results expected, required 1", sb.size());
    end else begin
      e = sb.pop_front();
      chk("qx", 32'(bus.qx), 32'(e.x));
      chk("qy", 32'(bus.qy), 32'(e.y));
      chk("q_inf", 32'(bus.q_inf), 32'(e.inf));
    end
    chk("busy_at_done", 32'(bus.busy), 32'd1);
    chk("busy_throughout", 32'(busy_ok), 32'd1);
    checks++;
    if (lat > BOUND) begin
      failures++;
      $display("FAIL latency: got %0d cycles, required at most %0d", lat, BOUND);
    end
    @(negedge clock);
    chk("done_single_pulse", 32'(bus.done), 32'd0);
    chk("busy_falls_with_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 20000 cycles");
    $fatal(1);
  end

  initial begin
    pt_t e;
    pt_t pff;
    int  seen;
    checks   = 0;
    failures = 0;
    vecs[0] = '{k: 4'd1,  px: 4'd1, py: 4'd1, pinf: 1'b0, ex: 4'd1, ey: 4'd1, einf: 1'b0};
    vecs[1] = '{k: 4'd2,  px: 4'd1, py: 4'd1, pinf: 1'b0, ex: 4'd0, ey: 4'd1, einf: 1'b0};
    vecs[2] = '{k: 4'd3,  px: 4'd1, py: 4'd1, pinf: 1'b0, ex: 4'd1, ey: 4'd0, einf: 1'b0};
    vecs[3] = '{k: 4'd4,  px: 4'd1, py: 4'd1, pinf: 1'b0, ex: 4'd0, ey: 4'd0, einf: 1'b1};
    vecs[4] = '{k: 4'd5,  px: 4'd1, py: 4'd1, pinf: 1'b0, ex: 4'd1, ey: 4'd1, einf: 1'b0};
    vecs[5] = '{k: 4'd0,  px: 4'd1, py: 4'd1, pinf: 1'b0, ex: 4'd0, ey: 4'd0, einf: 1'b1};
    vecs[6] = '{k: 4'd15, px: 4'd1, py: 4'd1, pinf: 1'b1, ex: 4'd0, ey: 4'd0, einf: 1'b1};
    vecs[7] = '{k: 4'd15, px: 4'd1, py: 4'd1, pinf: 1'b0, ex: 4'd1, ey: 4'd0, einf: 1'b0};

    reset = 1'b1;
    bus.start = 1'b0;  bus.k = '0;  bus.px = '0;  bus.py = '0;
    bus.p_inf = 1'b0;  bus.a = A_COEF;  bus.f = F_POLY;
    repeat (3) @(negedge clock);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_q_inf", 32'(bus.q_inf), 32'd1);
    chk("reset_qx", 32'(bus.qx), 32'd0);
    chk("reset_qy", 32'(bus.qy), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    foreach (vecs[i]) begin
      e = '{inf: vecs[i].einf, x: vecs[i].ex, y: vecs[i].ey};
      issue(vecs[i].k, vecs[i].px, vecs[i].py, vecs[i].pinf, 1'b1, e);
      wait_result(1);
    end

    // second start while busy is dropped; back-to-back start right after done is taken
    issue(4'd3, 4'd1, 4'd1, 1'b0, 1'b1, '{inf: 1'b0, x: 4'd1, y: 4'd0});
    repeat (3) @(negedge clock);
    bus.k = 4'd2;  bus.px = 4'd1;  bus.py = 4'd1;  bus.p_inf = 1'b0;
    bus.a = A_COEF;  bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    wait_result(5);
    issue(4'd2, 4'd1, 4'd1, 1'b0, 1'b1, '{inf: 1'b0, x: 4'd0, y: 4'd1});
    wait_result(1);

    // abort a k=7 run five cycles in
    issue(4'd7, 4'd1, 4'd1, 1'b0, 1'b0, '{inf: 1'b1, x: 4'd0, y: 4'd0});
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_q_inf", 32'(bus.q_inf), 32'd1);
    chk("abort_qx", 32'(bus.qx), 32'd0);
    chk("abort_qy", 32'(bus.qy), 32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge clock);
      if (bus.done) seen++;
    end
    chk("no_done_after_abort", 32'(seen), 32'd0);
    issue(4'd7, 4'd1, 4'd1, 1'b0, 1'b1, '{inf: 1'b0, x: 4'd1, y: 4'd0});
    wait_result(1);

    pff = '{inf: 1'b0, x: 4'hF, y: 4'hF};
    for (int kk = 0; kk < 16; kk++) begin
      e = m_smul(kk, pff);
      issue(4'(kk), 4'hF, 4'hF, 1'b0, 1'b1, e);
      wait_result(1);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
